// File: rtl/matmul_apb_master.sv
// APB requester: one valid/ready command in, one SETUP/ACCESS transfer on the bus, one valid/ready response out.
// Optional ACCESS watchdog enabled by defining MATMUL_APB_TIMEOUT_EN (abort after TIMEOUT_CYCLES wait states).
module matmul_apb_master #(
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]    cmd_wdata_i,
    input  logic [BUS_WIDTH/8-1:0]  cmd_pstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [BUS_WIDTH-1:0]    rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [BUS_WIDTH-1:0]    pwdata_o,
    output logic [BUS_WIDTH/8-1:0]  pstrb_o,
    input  logic [BUS_WIDTH-1:0]    prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);

    localparam int STRB_W = BUS_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                 state_q, state_d;
    logic                   write_q, write_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BUS_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]      strb_q, strb_d;
    logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   misaligned;

`ifdef MATMUL_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
`endif

    assign misaligned = |(cmd_addr_i & ALIGN_MASK);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MATMUL_APB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MATMUL_APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MATMUL_APB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    write_d = cmd_write_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    strb_d  = cmd_pstrb_i;
`ifdef MATMUL_APB_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    // Misaligned commands are refused locally without touching the bus.
                    if (misaligned) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
`ifdef MATMUL_APB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    rdata_d = (!write_q && !pslverr_i) ? prdata_i : '0;
                    err_d   = pslverr_i;
                    state_d = RESP;
                end
`ifdef MATMUL_APB_TIMEOUT_EN
                else if (cnt_q >= CNT_LIMIT) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus control decodes straight from the state register so reset drops it asynchronously.
    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o   = (state_q == ACCESS);
    assign pwrite_o    = write_q;
    assign paddr_o     = addr_q;
    assign pwdata_o    = wdata_q;
    assign pstrb_o     = write_q ? strb_q : '0;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

`ifdef MATMUL_APB_TIMEOUT_EN
    assign rsp_timeout_o = timeout_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_apb_master.sv
// Randomised bench for matmul_apb_master: a reactive APB slave plus a transaction-level
// model predicting latency, ACCESS length and response fields for each command.
module tb_matmul_apb_master;

    localparam int BW = 32;
    localparam int AW = 16;
    localparam int TO = 8;
`ifdef MATMUL_APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_wdata;
    logic [3:0]    cmd_pstrb;
    logic          rsp_valid, rsp_ready;
    logic [BW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [BW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [BW-1:0] prdata;
    logic          pready, pslverr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matmul_apb_master #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_pstrb_i(cmd_pstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata),
        .pready_i(pready), .pslverr_i(pslverr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          lat;
        int          acc;
        logic        apb;
        logic        err;
        logic        to;
        logic [31:0] rdata;
    } exp_t;

    // Transaction-level expectation from the command, slave wait states and slave reply.
    function automatic exp_t model(input logic wr, input logic [15:0] addr, input int waits,
                                   input logic slverr, input logic [31:0] data);
        exp_t e;
        if (addr % 4 != 0) begin
            e = '{lat: 1, acc: 0, apb: 1'b0, err: 1'b1, to: 1'b0, rdata: 32'h0};
        end else if (TO_EN && waits >= TO) begin
            e = '{lat: 2 + TO, acc: TO, apb: 1'b1, err: 1'b1, to: 1'b1, rdata: 32'h0};
        end else begin
            e.lat   = 3 + waits;
            e.acc   = waits + 1;
            e.apb   = 1'b1;
            e.err   = slverr;
            e.to    = 1'b0;
            e.rdata = (wr || slverr) ? 32'h0 : data;
        end
        return e;
    endfunction

    task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic slverr,
                          input logic [31:0] data, input int hold);
        exp_t e;
        int   n, acc;
        logic seen_psel, got;
        e = model(wr, addr, waits, slverr, data);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_pstrb = strb;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0; acc = 0; seen_psel = 1'b0; got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            n++;
            pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                if (psel) seen_psel = 1'b1;
                if (n == 1 && psel) check("setup_penable", penable, 0);
                if (psel && penable) begin
                    acc++;
                    check("paddr", paddr, addr);
                    check("pwrite", pwrite, wr);
                    check("pstrb", pstrb, wr ? strb : 4'h0);
                    if (wr) check("pwdata", pwdata, wdata);
                    if (acc == waits + 1) begin
                        pready = 1'b1; pslverr = slverr; prdata = data;
                    end
                end
            end
        end
        pready = 1'b0;
        check("rsp_within_bound", got, 1);
        check("latency", 64'(n), 64'(e.lat));
        check("access_cycles", 64'(acc), 64'(e.acc));
        check("apb_activity", seen_psel, e.apb);
        check("rsp_err", rsp_err, e.err);
        check("rsp_timeout", rsp_timeout, e.to);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("cmd_ready_resp", cmd_ready, 0);
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, e.rdata);
            check("hold_err", rsp_err, e.err);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("post_rsp_valid", rsp_valid, 0);
        check("post_cmd_ready", cmd_ready, 1);
        $display("txn wr=%0d addr=0x%04h waits=%0d slverr=%0d hold=%0d lat=%0d rdata=0x%08h err=%0d",
                 wr, addr, waits, slverr, hold, n, rsp_rdata, rsp_err);
    endtask

    initial begin
        logic [15:0] a;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_pstrb = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pstrb", pstrb, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;

        do_txn(1'b1, 16'h0010, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 32'h0, 0);
        do_txn(1'b0, 16'h0020, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 0);
        do_txn(1'b0, 16'h0004, 32'h0, 4'h0, 1, 1'b1, 32'hDEAD_BEEF, 0);
        do_txn(1'b1, 16'h0003, 32'h1111_2222, 4'h3, 0, 1'b0, 32'h0, 0);
        do_txn(1'b0, 16'h0030, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D, 5);

        // Reset in the middle of ACCESS must kill the bus and the pending response at once.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0040;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_penable", penable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_psel", psel, 0);
        check("async_rst_penable", penable, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_psel", psel, 0);

        if (TO_EN) begin
            do_txn(1'b0, 16'h0080, 32'h0, 4'h0, 20, 1'b0, 32'h5555_AAAA, 0);
            do_txn(1'b0, 16'h0084, 32'h0, 4'h0, TO - 1, 1'b0, 32'h7777_8888, 0);
        end

        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom) & 16'hFFFC;
            if ($urandom_range(0, 4) == 0) a = a | 16'($urandom_range(1, 3));
            do_txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 5)),
                   ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_apb_master.md
# matmul_apb_master

APB requester that drives register and scratchpad transfers into the matmul APB slave. It accepts one command at a time on a valid/ready command port and runs a full APB SETUP/ACCESS transfer, honouring slave wait states. It returns read data and error status on a valid/ready response port. It sits between the test or host sequencer and the matmul slave's APB port, and is the initiator end of the same bus the matmul checker monitors.

## Interface
- BUS_WIDTH, 32, APB data width in bits (multiple of 8)
- ADDR_WIDTH, 16, APB address width in bits
- TIMEOUT_CYCLES, 64, maximum ACCESS cycles before abort (used only with MATMUL_APB_TIMEOUT_EN)
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted this cycle when both high
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  byte address
- cmd_wdata_i  in  BUS_WIDTH  write data
- cmd_pstrb_i  in  BUS_WIDTH/8  write byte strobes
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  BUS_WIDTH  read data (0 for writes and errors)
- rsp_err_o  out  1  slave error, misalignment or timeout
- rsp_timeout_o  out  1  transfer aborted by watchdog
- psel_o, penable_o, pwrite_o  out  1  APB control
- paddr_o  out  ADDR_WIDTH  APB address
- pwdata_o  out  BUS_WIDTH  APB write data
- pstrb_o  out  BUS_WIDTH/8  APB strobes
- prdata_i  in  BUS_WIDTH  APB read data
- pready_i, pslverr_i  in  1  APB completion and error

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready_o=1. On cmd_valid_i, register write, addr, wdata and strobes.
  - If aligned (addr mod BUS_WIDTH/8 == 0), go to SETUP.
  - If misaligned, go directly to RESP with rsp_err_o=1 and no APB activity.
- SETUP: psel_o=1, penable_o=0. Always go to ACCESS next cycle.
- ACCESS: psel_o=1, penable_o=1. Stay while pready_i=0.
  - When pready_i=1, capture prdata_i (reads only; writes return 0) and pslverr_i, then go to RESP.
  - If pslverr_i=1 on a read, rsp_rdata_o=0.
- RESP: rsp_valid_o=1 with stable rsp_* fields until rsp_ready_i=1, then go to IDLE. No command is accepted in RESP.
- pstrb_o equals the registered strobes for writes and is forced to 0 for reads.
- paddr_o, pwrite_o, pwdata_o and pstrb_o are stable from SETUP through the last ACCESS cycle, and hold their last values in IDLE/RESP.
- psel_o and penable_o are 0 in IDLE and RESP.
- pready_i and pslverr_i are ignored outside ACCESS.

## Timing
- Reset: all outputs 0 except cmd_ready_o=1; state IDLE.
- Reset asserted mid-transfer: psel_o and penable_o drop to 0 asynchronously, and any pending response is discarded.
- Command accepted at edge T:
  - SETUP during cycle T+1.
  - ACCESS from T+2.
  - With zero wait states (pready_i=1 at T+2), rsp_valid_o=1 at T+3.
- Each wait state adds one cycle.
- With rsp_ready_i held high, RESP lasts one cycle and the next command can be accepted at T+4. Peak throughput is one transfer per 4 cycles.
- A misaligned command gives rsp_valid_o one cycle after acceptance.
- All response fields are registered; there is no combinational path from APB inputs to rsp_* outputs.

## Configuration
- MATMUL_APB_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When the count reaches TIMEOUT_CYCLES, drop psel_o and penable_o next cycle and go to RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - pready_i in the same cycle as the limit wins and the transfer completes normally.
- MATMUL_APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; rsp_timeout_o tied 0.

## Test plan
- Write addr 0x0010, data 0xA5A5_5A5A, strobe 0xF, slave pready_i=1 immediately:
  - SETUP at T+1 and ACCESS at T+2 with paddr_o=0x0010, pwrite_o=1, pstrb_o=0xF.
  - rsp_valid_o=1, rsp_err_o=0, rsp_rdata_o=0 at T+3.
- Read addr 0x0020 with slave inserting 3 wait states and returning 0x1234_5678:
  - penable_o high for 4 cycles with paddr_o stable and pstrb_o=0.
  - rsp_rdata_o=0x1234_5678 at T+6.
- Read addr 0x0004 with pslverr_i=1 at completion -> rsp_err_o=1, rsp_rdata_o=0.
- Command at addr 0x0003 -> no psel_o pulse; rsp_valid_o=1, rsp_err_o=1 one cycle after acceptance.
- Hold rsp_ready_i=0 for 5 cycles after a read while cmd_valid_i stays high:
  - rsp_* stable and cmd_ready_o=0 throughout.
  - Second command accepted the cycle after rsp_ready_i=1.
- Deassert rst_ni during ACCESS -> psel_o, penable_o, rsp_valid_o go 0 immediately; after release, cmd_ready_o=1. With MATMUL_APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready_i held 0 -> abort with rsp_timeout_o=1.
